// File: rtl/fxyz_pkg.sv
// Shared types and constants for the fxyz sweep controller.
// The golden truth table is s = (y|z) & (~x|z) evaluated over {x,y,z} = 0..7.
package fxyz_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_FINISH
    } state_e;

    localparam int            NUM_VEC     = 8;
    localparam int            IDX_W       = 3;
    localparam int            CNT_W       = 4;
    localparam logic [7:0]    FXYZ_GOLDEN = 8'hAE;
    localparam int            FXYZ_ONES   = 5;

endpackage

// File: rtl/fxyz_sweep_ctrl_if.sv
// Control/result bundle of the sweep controller; the controller is the slave,
// whoever launches sweeps and reads results is the master.
interface fxyz_sweep_ctrl_if;

    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       x_o;
    logic       y_o;
    logic       z_o;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic [3:0] ones_cnt;
    logic       match;

    modport master (
        output start, abort, expected,
        input  x_o, y_o, z_o, busy, done, table_out, ones_cnt, match
    );

    modport slave (
        input  start, abort, expected,
        output x_o, y_o, z_o, busy, done, table_out, ones_cnt, match
    );

endinterface

// File: rtl/fxyz_sweep_ctrl_fxyz.sv
// The fxyz function block under characterisation: purely combinational.
module fxyz (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic s
);

    assign s = (y | z) & (~x | z);

endmodule

// File: rtl/fxyz_sweep_ctrl.sv
// Sweeps fxyz through all eight input vectors, builds its truth table and
// compares it with a golden mask latched at start.
module fxyz_sweep_ctrl
    import fxyz_pkg::*;
#(
    parameter int SETTLE   = 1,
    parameter int SETTLE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    fxyz_sweep_ctrl_if.slave   bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(NUM_VEC - 1);

    state_e               state_q,    state_d;
    logic [IDX_W-1:0]     idx_q,      idx_d;
    logic [SETTLE_W-1:0]  wcnt_q,     wcnt_d;
    logic [NUM_VEC-1:0]   work_tbl_q, work_tbl_d;
    logic [CNT_W-1:0]     work_cnt_q, work_cnt_d;
    logic [NUM_VEC-1:0]   exp_q,      exp_d;
    logic [IDX_W-1:0]     vec_q,      vec_d;
    logic                 done_q,     done_d;
    logic [NUM_VEC-1:0]   tbl_q,      tbl_d;
    logic [CNT_W-1:0]     ones_q,     ones_d;
    logic                 match_q,    match_d;
    logic                 s;

    // The vector applied to fxyz comes straight from flops, so s is stable
    // for the whole SETTLE window before CAPTURE samples it.
    fxyz u_fxyz (
        .x (vec_q[2]),
        .y (vec_q[1]),
        .z (vec_q[0]),
        .s (s)
    );

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        wcnt_d     = wcnt_q;
        work_tbl_d = work_tbl_q;
        work_cnt_d = work_cnt_q;
        exp_d      = exp_q;
        done_d     = 1'b0;
        tbl_d      = tbl_q;
        ones_d     = ones_q;
        match_d    = match_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    idx_d      = '0;
                    wcnt_d     = '0;
                    work_tbl_d = '0;
                    work_cnt_d = '0;
                    exp_d      = bus.expected;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q + SETTLE_W'(1);
                    if (wcnt_q == SETTLE_LAST) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    work_tbl_d[idx_q] = s;
                    work_cnt_d        = work_cnt_q + {{(CNT_W-1){1'b0}}, s};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        wcnt_d  = '0;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_FINISH: begin
                // Results are published only here, so an aborted or reset sweep
                // never exposes a partial table.
                tbl_d   = work_tbl_q;
                ones_d  = work_cnt_q;
                match_d = (work_tbl_q == exp_q);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        vec_d = (state_d == ST_IDLE) ? '0 : idx_d;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            wcnt_q     <= '0;
            work_tbl_q <= '0;
            work_cnt_q <= '0;
            exp_q      <= '0;
            vec_q      <= '0;
            done_q     <= 1'b0;
            tbl_q      <= '0;
            ones_q     <= '0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wcnt_q     <= wcnt_d;
            work_tbl_q <= work_tbl_d;
            work_cnt_q <= work_cnt_d;
            exp_q      <= exp_d;
            vec_q      <= vec_d;
            done_q     <= done_d;
            tbl_q      <= tbl_d;
            ones_q     <= ones_d;
            match_q    <= match_d;
        end
    end

    assign bus.x_o       = vec_q[2];
    assign bus.y_o       = vec_q[1];
    assign bus.z_o       = vec_q[0];
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.table_out = tbl_q;
    assign bus.ones_cnt  = ones_q;
    assign bus.match     = match_q;

endmodule

// File: tb/tb_fxyz_sweep_ctrl.sv
// Bench for fxyz_sweep_ctrl: one instance with SETTLE=1, one with SETTLE=3,
// each with a scoreboard of expected sweep results popped on done.
module tb_fxyz_sweep_ctrl;

    localparam logic [7:0] GOLD      = 8'hAE;
    localparam logic [3:0] GOLD_ONES = 4'd5;
    localparam int         LAT_A     = 8 * (1 + 1) + 1;
    localparam int         LAT_B     = 8 * (3 + 1) + 1;

    typedef struct {
        logic [7:0] tbl;
        logic [3:0] ones;
        logic       match;
        int         done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n_a;
    logic rst_n_b;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   dones_a = 0;
    int   dones_b = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fxyz_sweep_ctrl_if ifa ();
    fxyz_sweep_ctrl_if ifb ();

    fxyz_sweep_ctrl #(.SETTLE(1), .SETTLE_W(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (ifa)
    );

    fxyz_sweep_ctrl #(.SETTLE(3), .SETTLE_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (ifb)
    );

    // Scoreboard for instance A: every done must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n_a === 1'b1 && ifa.done === 1'b1) begin
            dones_a++;
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL a_unexpected_done: done seen at cycle %0d, required no done", cyc);
            end else begin
                ea = qa.pop_front();
                if (cyc !== ea.done_cyc) begin
                    bad++;
                    $display("FAIL a_latency: done at cycle %0d, required %0d", cyc, ea.done_cyc);
                end
                total++;
                if (ifa.table_out !== ea.tbl) begin
                    bad++;
                    $display("FAIL a_table: got %h, required %h", ifa.table_out, ea.tbl);
                end
                total++;
                if (ifa.ones_cnt !== ea.ones) begin
                    bad++;
                    $display("FAIL a_ones: got %0d, required %0d", ifa.ones_cnt, ea.ones);
                end
                total++;
                if (ifa.match !== ea.match) begin
                    bad++;
                    $display("FAIL a_match: got %b, required %b", ifa.match, ea.match);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n_b === 1'b1 && ifb.done === 1'b1) begin
            dones_b++;
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL b_unexpected_done: done seen at cycle %0d, required no done", cyc);
            end else begin
                eb = qb.pop_front();
                if (cyc !== eb.done_cyc) begin
                    bad++;
                    $display("FAIL b_latency: done at cycle %0d, required %0d", cyc, eb.done_cyc);
                end
                total++;
                if (ifb.table_out !== eb.tbl || ifb.ones_cnt !== eb.ones || ifb.match !== eb.match) begin
                    bad++;
                    $display("FAIL b_result: got tbl=%h ones=%0d match=%b, required tbl=%h ones=%0d match=%b",
                             ifb.table_out, ifb.ones_cnt, ifb.match, eb.tbl, eb.ones, eb.match);
                end
            end
        end
    end

    task automatic wait_drain_a(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (qa.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_drain_b(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (qb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic push_a(input logic [7:0] exp_mask, input int done_cyc);
        exp_t e;
        e.tbl      = GOLD;
        e.ones     = GOLD_ONES;
        e.match    = (exp_mask == GOLD);
        e.done_cyc = done_cyc;
        qa.push_back(e);
    endtask

    task automatic test_reset();
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.expected = 8'h00;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.expected = 8'h00;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        #12;
        total++;
        if ({ifa.busy, ifa.done, ifa.match, ifa.x_o, ifa.y_o, ifa.z_o, ifa.table_out, ifa.ones_cnt} !== 18'd0) begin
            bad++;
            $display("FAIL reset_a: outputs %h, required 0",
                     {ifa.busy, ifa.done, ifa.match, ifa.x_o, ifa.y_o, ifa.z_o, ifa.table_out, ifa.ones_cnt});
        end
        total++;
        if ({ifb.busy, ifb.done, ifb.match, ifb.x_o, ifb.y_o, ifb.z_o, ifb.table_out, ifb.ones_cnt} !== 18'd0) begin
            bad++;
            $display("FAIL reset_b: outputs %h, required 0",
                     {ifb.busy, ifb.done, ifb.match, ifb.x_o, ifb.y_o, ifb.z_o, ifb.table_out, ifb.ones_cnt});
        end
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b, required 0", ifa.busy);
        end
    endtask

    task automatic test_golden();
        bit ok;
        @(negedge clk);
        ifa.expected = GOLD;
        ifa.start    = 1'b1;
        push_a(GOLD, cyc + 1 + LAT_A);
        @(negedge clk);
        ifa.start = 1'b0;
        total++;
        if (ifa.busy !== 1'b1 || {ifa.x_o, ifa.y_o, ifa.z_o} !== 3'd0) begin
            bad++;
            $display("FAIL golden_start: busy=%b vec=%0d, required busy=1 vec=0",
                     ifa.busy, {ifa.x_o, ifa.y_o, ifa.z_o});
        end
        wait_drain_a(40, ok);
        total++;
        if (!ok || ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL golden_end: drained=%b busy=%b, required drained=1 busy=0", ok, ifa.busy);
        end
    endtask

    task automatic test_mismatch();
        bit ok;
        @(negedge clk);
        ifa.expected = 8'hAF;
        ifa.start    = 1'b1;
        push_a(8'hAF, cyc + 1 + LAT_A);
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (5) @(negedge clk);
        ifa.expected = GOLD;
        wait_drain_a(40, ok);
        total++;
        if (!ok || ifa.match !== 1'b0) begin
            bad++;
            $display("FAIL mismatch_end: drained=%b match=%b, required drained=1 match=0", ok, ifa.match);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d0;
        int c0;
        @(negedge clk);
        d0 = dones_a;
        c0 = cyc;
        ifa.expected = GOLD;
        ifa.start    = 1'b1;
        for (int k = 1; k <= 3; k++) push_a(GOLD, c0 + 18 * k);
        repeat (40) @(negedge clk);
        ifa.start = 1'b0;
        wait_drain_a(40, ok);
        repeat (20) @(negedge clk);
        total++;
        if (!ok || dones_a - d0 !== 3 || ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back: drained=%b dones=%0d busy=%b, required drained=1 dones=3 busy=0",
                     ok, dones_a - d0, ifa.busy);
        end
    endtask

    task automatic test_abort();
        bit ok;
        int d0;
        // start and abort together in IDLE: start wins
        @(negedge clk);
        ifa.expected = GOLD;
        ifa.start    = 1'b1;
        ifa.abort    = 1'b1;
        push_a(GOLD, cyc + 1 + LAT_A);
        @(negedge clk);
        ifa.start = 1'b0;
        ifa.abort = 1'b0;
        wait_drain_a(40, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL start_abort_idle: drained=%b, required 1", ok);
        end

        // abort while vector 4 is applied, start asserted alongside
        @(negedge clk);
        d0 = dones_a;
        ifa.expected = 8'h00;
        ifa.start    = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if ({ifa.x_o, ifa.y_o, ifa.z_o} !== 3'b100) begin
            bad++;
            $display("FAIL vec_idx4: got %b, required 100", {ifa.x_o, ifa.y_o, ifa.z_o});
        end
        ifa.abort = 1'b1;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.abort = 1'b0;
        ifa.start = 1'b0;
        total++;
        if (ifa.busy !== 1'b0 || {ifa.x_o, ifa.y_o, ifa.z_o} !== 3'd0) begin
            bad++;
            $display("FAIL abort_busy: busy=%b vec=%0d, required busy=0 vec=0",
                     ifa.busy, {ifa.x_o, ifa.y_o, ifa.z_o});
        end
        repeat (25) @(negedge clk);
        total++;
        if (dones_a !== d0 || ifa.table_out !== GOLD || ifa.ones_cnt !== GOLD_ONES || ifa.match !== 1'b1) begin
            bad++;
            $display("FAIL abort_keep: dones=%0d tbl=%h ones=%0d match=%b, required dones=%0d tbl=%h ones=%0d match=1",
                     dones_a, ifa.table_out, ifa.ones_cnt, ifa.match, d0, GOLD, GOLD_ONES);
        end

        // abort and start during FINISH are both ignored
        @(negedge clk);
        ifa.expected = 8'hAF;
        ifa.start    = 1'b1;
        push_a(8'hAF, cyc + 1 + LAT_A);
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (16) @(negedge clk);
        ifa.abort = 1'b1;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.abort = 1'b0;
        ifa.start = 1'b0;
        #1;
        total++;
        if (qa.size() !== 0 || ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_finish: pending=%0d busy=%b, required pending=0 busy=0", qa.size(), ifa.busy);
        end
        repeat (3) @(negedge clk);
        total++;
        if (ifa.busy !== 1'b0) begin
            bad++;
            $display("FAIL start_in_finish: busy=%b, required 0", ifa.busy);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        ifa.expected = GOLD;
        ifa.start    = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n_a = 1'b0;
        #1;
        total++;
        if ({ifa.busy, ifa.done, ifa.match, ifa.x_o, ifa.y_o, ifa.z_o, ifa.table_out, ifa.ones_cnt} !== 18'd0) begin
            bad++;
            $display("FAIL async_reset_a: outputs %h, required 0",
                     {ifa.busy, ifa.done, ifa.match, ifa.x_o, ifa.y_o, ifa.z_o, ifa.table_out, ifa.ones_cnt});
        end
        @(negedge clk);
        rst_n_a = 1'b1;
        repeat (25) @(negedge clk);
        total++;
        if (ifa.busy !== 1'b0 || ifa.table_out !== 8'h00) begin
            bad++;
            $display("FAIL after_reset_a: busy=%b tbl=%h, required busy=0 tbl=00", ifa.busy, ifa.table_out);
        end
    endtask

    task automatic test_settle3();
        bit   ok;
        exp_t e;
        @(negedge clk);
        ifb.expected = GOLD;
        ifb.start    = 1'b1;
        e.tbl      = GOLD;
        e.ones     = GOLD_ONES;
        e.match    = 1'b1;
        e.done_cyc = cyc + 1 + LAT_B;
        qb.push_back(e);
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            ifb.start = 1'b0;
            total++;
            if ({ifb.x_o, ifb.y_o, ifb.z_o} !== 3'(k / 4)) begin
                bad++;
                $display("FAIL settle3_vec: cycle %0d got %0d, required %0d", k, {ifb.x_o, ifb.y_o, ifb.z_o}, k / 4);
            end
        end
        wait_drain_b(20, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL settle3_drain: drained=%b, required 1", ok);
        end

        @(negedge clk);
        ifb.start = 1'b1;
        @(negedge clk);
        ifb.start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        rst_n_b = 1'b0;
        #1;
        total++;
        if ({ifb.busy, ifb.done, ifb.match, ifb.x_o, ifb.y_o, ifb.z_o, ifb.table_out, ifb.ones_cnt} !== 18'd0) begin
            bad++;
            $display("FAIL settle3_reset: outputs %h, required 0",
                     {ifb.busy, ifb.done, ifb.match, ifb.x_o, ifb.y_o, ifb.z_o, ifb.table_out, ifb.ones_cnt});
        end
        @(negedge clk);
        rst_n_b = 1'b1;
        repeat (40) @(negedge clk);
        total++;
        if (ifb.busy !== 1'b0 || ifb.table_out !== 8'h00) begin
            bad++;
            $display("FAIL settle3_after_reset: busy=%b tbl=%h, required busy=0 tbl=00", ifb.busy, ifb.table_out);
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_mismatch();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_settle3();
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL leftover: pending a=%0d b=%0d, required 0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
